ser2par_loader: RTL and testbench
=================================

Name: ser2par_loader

Overview:
- Serial-to-parallel front end that feeds the `regN` load register.
- Collects WIDTH serial bits under a start/shift-enable protocol.
- When the word is complete, it presents it on `d` with a single-cycle `ld` pulse. The downstream `regN` captures that word on the next `ck` edge.
- Also reports `busy`, plus a sticky overrun flag for protocol misuse.

Parameters:
- WIDTH, 8: word width; must match the WIDTH of the downstream `regN`. Legal range 2..32.
- MSB_FIRST, 1: 1 = first serial bit lands in `d[WIDTH-1]` (shift left); 0 = first bit lands in `d[0]` (shift right).

Ports:
- ck  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous abort / flag clear.
- start  input  1  begin a new word.
- sen  input  1  shift enable; `sin` is sampled only when sen=1.
- sin  input  1  serial data bit.
- ld  output  1  one-cycle load strobe to `regN`.
- d  output  WIDTH  assembled word; feeds `regN`'s d input.
- busy  output  1  high in SHIFT and LOAD.
- ovr  output  1  sticky protocol-error flag.

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE; shift register=0; bit counter=0.
  - d=0, ld=0, busy=0, ovr=0.
- States: IDLE, SHIFT, LOAD. State and counter are registered. `ld` and `busy` are decoded from state only (Moore).
- IDLE:
  - start=1 → SHIFT; counter=0; shift register=0.
  - sen and sin are ignored.
- SHIFT, sen=1:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], sin}.
  - MSB_FIRST=0: sr <= {sin, sr[WIDTH-1:1]}.
  - counter increments.
- SHIFT, sen=0: hold shift register and counter; no timeout.
- Word complete: on the edge that accepts the WIDTH-th bit (counter==WIDTH-1 and sen=1):
  - d <= completed word, including that final bit.
  - state → LOAD.
- LOAD: lasts exactly one cycle.
  - ld=1; d stable and valid. `regN` captures d on the next edge.
  - Next state: SHIFT if start=1 (back-to-back, counter=0, shift register=0); otherwise IDLE.
  - sen during LOAD is ignored; the bit is not captured.
- Latency: ld is high in the cycle immediately after the edge that sampled the last bit.
- d holding:
  - d changes only on the word-complete edge, on rst_n, or never otherwise.
  - d holds its value through IDLE and through the next word's SHIFT.
  - clr does not alter d.
- ovr:
  - Set to 1 on any edge where start=1 while state=SHIFT.
  - That start is otherwise ignored: the word in progress continues and the counter is not reset.
  - Cleared only by clr or rst_n.
- clr=1 (synchronous, highest priority after reset):
  - state → IDLE; counter=0; shift register=0; ovr=0; ld=0 next cycle.
  - If clr and start are both 1, clr wins; start is dropped.
- Counter width is ceil(log2(WIDTH)); it never wraps past WIDTH-1.
- rst_n asserted mid-SHIFT or in LOAD:
  - The partial word is discarded.
  - ld drops immediately (asynchronously); no load is issued.
- busy = (state==SHIFT) or (state==LOAD).

Test Plan (WIDTH=8 unless noted):
- Reset: rst_n=0 mid-cycle → d=00000000, ld=0, busy=0, ovr=0 immediately, without waiting for ck.
- MSB-first word:
  - Stimulus: start, then sen=1 for 8 cycles with sin = 0,0,0,0,0,0,1,1.
  - Required: ld=1 for exactly one cycle, d=00000011, busy drops the cycle after.
  - A `regN` instance driven by ld/d shows q=00000011 one edge later.
- Gapped back-to-back words:
  - Stimulus: word 00001111 with sen deasserted for 3 cycles mid-word, start held high during LOAD, then word 10100101.
  - Required: two ld pulses with d=00001111, then d=10100101; no IDLE cycle between the words.
- LSB-first (MSB_FIRST=0): sin = 1,1,0,0,0,0,0,0 → d=00000011.
- Overrun:
  - Stimulus: start pulsed after 4 bits of a word.
  - Required: ovr=1 and stays 1; the word still completes correctly after 4 more bits.
  - A following clr gives ovr=0 and state IDLE.
- Abort:
  - Stimulus: clr after 5 bits, then a new full word 11110000.
  - Required: no ld for the aborted word; d keeps its previous value until ld with d=11110000.

Source files
------------

// File: rtl/ser2par_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : ser2par_loader_if
//  Description : Bundle of the serial-input protocol and parallel-load outputs
//                of ser2par_loader.
//                master : drives clr/start/sen/sin, observes ld/d/busy/ovr
//                slave  : the loader itself
//  Revision    : 1.0  initial release
// ============================================================================
interface ser2par_loader_if #(
   parameter int WIDTH = 8
);
   logic             clr;    // synchronous abort / flag clear
   logic             start;  // begin a new word
   logic             sen;    // shift enable
   logic             sin;    // serial data bit
   logic             ld;     // one-cycle load strobe
   logic [WIDTH-1:0] d;      // assembled word
   logic             busy;   // high in SHIFT and LOAD
   logic             ovr;    // sticky protocol-error flag

   modport master (
      output clr, start, sen, sin,
      input  ld, d, busy, ovr
   );

   modport slave (
      input  clr, start, sen, sin,
      output ld, d, busy, ovr
   );
endinterface
`default_nettype wire

// File: rtl/ser2par_loader.sv
`default_nettype none
// ============================================================================
//  Module      : ser2par_loader
//  Description : Serial-to-parallel front end for a load register. Collects
//                WIDTH bits while sen=1, then presents the word on d with a
//                single-cycle ld strobe. Reports busy and a sticky overrun.
//  Ports       : ck    - clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - ser2par_loader_if.slave (clr/start/sen/sin in,
//                        ld/d/busy/ovr out)
//  Revision    : 1.0  initial release
// ============================================================================
module ser2par_loader #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                ck,
   input  logic                rst_n,
   ser2par_loader_if.slave     bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_LOAD  = 2'd2;

   logic [1:0]       state;
   logic [1:0]       state_nx;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] sr_shift;
   logic [WIDTH-1:0] d_q;
   logic             ovr_q;
   logic             word_done;
   logic             ld_w;
   logic             busy_w;

   // Shift direction decides which end of d the first serial bit reaches.
   generate
      if (MSB_FIRST) begin : g_msb_first
         assign sr_shift = {sr[WIDTH-2:0], bus.sin};
      end else begin : g_lsb_first
         assign sr_shift = {bus.sin, sr[WIDTH-1:1]};
      end
   endgenerate

   assign word_done = (state == S_SHIFT) && bus.sen && (cnt == LAST);

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_nx = state;
      if (bus.clr) begin
         state_nx = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (bus.start) state_nx = S_SHIFT;
            S_SHIFT: if (word_done) state_nx = S_LOAD;
            S_LOAD:  state_nx = bus.start ? S_SHIFT : S_IDLE;
            default: state_nx = S_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------ Moore outputs
   always_comb begin
      ld_w   = (state == S_LOAD);
      busy_w = (state == S_SHIFT) || (state == S_LOAD);
   end

   // ----------------------------------------------------------------- datapath
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         sr    <= '0;
         d_q   <= '0;
         ovr_q <= 1'b0;
      end else if (bus.clr) begin
         // d deliberately untouched: the last loaded word stays visible.
         cnt   <= '0;
         sr    <= '0;
         ovr_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  cnt <= '0;
                  sr  <= '0;
               end
            end
            S_SHIFT: begin
               // A start mid-word only flags the error; the word carries on.
               if (bus.start) ovr_q <= 1'b1;
               if (bus.sen) begin
                  sr <= sr_shift;
                  if (cnt == LAST) begin
                     cnt <= '0;
                     d_q <= sr_shift;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            S_LOAD: begin
               // Cleared either way so a back-to-back word starts from zero.
               cnt <= '0;
               sr  <= '0;
            end
            default: begin
               cnt <= '0;
               sr  <= '0;
            end
         endcase
      end
   end

   assign bus.ld   = ld_w;
   assign bus.busy = busy_w;
   assign bus.d    = d_q;
   assign bus.ovr  = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_ser2par_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ser2par_loader
//  Description : Self-checking bench. One stimulus stream drives an MSB-first
//                and an LSB-first loader (WIDTH=8); a protocol-level model
//                predicts ld/busy/ovr/d for both every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ser2par_loader;

   localparam int W = 8;

   logic ck = 1'b0;
   logic rst_n = 1'b1;
   logic clr = 1'b0, start = 1'b0, sen = 1'b0, sin = 1'b0;

   int checks = 0;
   int errors = 0;

   ser2par_loader_if #(.WIDTH(W)) m_if ();
   ser2par_loader_if #(.WIDTH(W)) l_if ();

   assign m_if.clr = clr;  assign m_if.start = start;
   assign m_if.sen = sen;  assign m_if.sin   = sin;
   assign l_if.clr = clr;  assign l_if.start = start;
   assign l_if.sen = sen;  assign l_if.sin   = sin;

   ser2par_loader #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.ck(ck), .rst_n(rst_n), .bus(m_if));
   ser2par_loader #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.ck(ck), .rst_n(rst_n), .bus(l_if));

   always #5 ck = ~ck;

   // Stand-in for the downstream regN: captures d on the edge after ld.
   logic [W-1:0] regq = '0;
   always @(posedge ck) if (m_if.ld) regq <= m_if.d;

   // ---------------- protocol-level reference model
   bit           active = 0;   // collecting a word
   bit           loading = 0;  // word just completed, strobe cycle
   bit           m_ovr = 0;
   bit           q[$];         // bits received so far, in arrival order
   logic [W-1:0] exp_msb = '0;
   logic [W-1:0] exp_lsb = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic model_edge(input bit s, input bit e, input bit b, input bit c);
      if (c) begin
         active = 0; loading = 0; m_ovr = 0; q.delete();
      end else if (loading) begin
         loading = 0; active = s; q.delete();
      end else if (active) begin
         if (s) m_ovr = 1;
         if (e) begin
            q.push_back(b);
            if (q.size() == W) begin
               exp_msb = '0; exp_lsb = '0;
               foreach (q[k]) begin
                  exp_msb = exp_msb * 2 + W'(q[k]);  // first bit ends up on top
                  exp_lsb = exp_lsb | (W'(q[k]) << k); // first bit ends up at d[0]
               end
               loading = 1; active = 0; q.delete();
            end
         end
      end else if (s) begin
         active = 1; q.delete();
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".ld"},    32'(m_if.ld),   32'(loading));
      chk({tag, ".busy"},  32'(m_if.busy), 32'(active | loading));
      chk({tag, ".ovr"},   32'(m_if.ovr),  32'(m_ovr));
      chk({tag, ".d_msb"}, 32'(m_if.d),    32'(exp_msb));
      chk({tag, ".d_lsb"}, 32'(l_if.d),    32'(exp_lsb));
      chk({tag, ".ld_lsb"},32'(l_if.ld),   32'(loading));
   endtask

   task automatic step(input string tag, input bit s, input bit e, input bit b, input bit c);
      start = s; sen = e; sin = b; clr = c;
      model_edge(s, e, b, c);
      @(posedge ck); #1;
      check_outputs(tag);
   endtask

   // mode: 0 = idle after LOAD, 1 = start held in LOAD, 2 = stop while in LOAD
   task automatic send_word(input string tag, input logic [W-1:0] w, input int gap_n,
                            input int gap_pct, input int mode, input int ovr_at, input int clr_at);
      if (!active) step({tag, ".start"}, 1, $urandom_range(0, 1), $urandom_range(0, 1), 0);
      for (int i = 0; i < W; i++) begin
         if (i == clr_at) begin
            step({tag, ".clr"}, 0, 1, 1, 1);
            return;
         end
         if (i == 4) for (int g = 0; g < gap_n; g++) step({tag, ".gap"}, 0, 0, $urandom_range(0, 1), 0);
         while (int'($urandom_range(0, 99)) < gap_pct) step({tag, ".rgap"}, 0, 0, $urandom_range(0, 1), 0);
         if (i == ovr_at) step({tag, ".ovr"}, 1, 0, 0, 0);
         step({tag, ".bit"}, 0, 1, w[W-1-i], 0);
      end
      if (mode == 0) step({tag, ".load"}, 0, $urandom_range(0, 1), $urandom_range(0, 1), 0);
      else if (mode == 1) step({tag, ".b2b"}, 1, $urandom_range(0, 1), $urandom_range(0, 1), 0);
   endtask

   initial begin
      // Asynchronous reset, observed before any clock edge.
      #2 rst_n = 1'b0;
      #1;
      check_outputs("reset_async");
      @(posedge ck); #1;
      check_outputs("reset_hold");
      rst_n = 1'b1;
      step("idle", 0, 1, 1, 0);

      // MSB-first 00000011 (LSB-first instance sees 11000000).
      send_word("msb03", 8'h03, 0, 0, 0, -1, -1);
      chk("regN.q", 32'(regq), 32'h03);

      // LSB-first: sin = 1,1,0,0,0,0,0,0 gives 00000011 on the LSB instance.
      send_word("lsb03", 8'hC0, 0, 0, 0, -1, -1);
      chk("lsb.d_plain", 32'(l_if.d), 32'h03);

      // Gapped word, start held during LOAD, then the next word.
      send_word("gap0f", 8'h0F, 3, 0, 1, -1, -1);
      send_word("b2ba5", 8'hA5, 0, 0, 0, -1, -1);

      // Overrun after 4 bits; word still completes; clr clears the flag.
      send_word("ovr",   8'h5A, 0, 0, 0, 4, -1);
      step("ovr_sticky", 0, 0, 0, 0);
      step("ovr_clr", 0, 0, 0, 1);

      // Abort after 5 bits (clr with start also asserted), then a full word.
      send_word("abort", 8'h3C, 0, 0, 0, -1, 5);
      step("clr_wins", 1, 1, 1, 1);
      send_word("f0",    8'hF0, 0, 0, 0, -1, -1);

      // Randomized words with gaps, back-to-back, overruns and aborts.
      for (int n = 0; n < 30; n++) begin
         send_word("rnd", W'($urandom), 0, 30, int'($urandom_range(0, 1)),
                   ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, W - 1)) : -1,
                   ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, W - 1)) : -1);
         if ($urandom_range(0, 3) == 0) step("rnd_clr", 0, 0, 0, 1);
      end
      if (active) send_word("drain", 8'h81, 0, 0, 0, -1, -1);

      // Reset while in LOAD with ovr set: ld drops without a clock edge.
      send_word("rst_load", 8'hE7, 0, 0, 2, 2, -1);
      #2 rst_n = 1'b0;
      active = 0; loading = 0; m_ovr = 0; q.delete(); exp_msb = '0; exp_lsb = '0;
      #1;
      check_outputs("reset_in_load");
      @(posedge ck); #1;
      rst_n = 1'b1;
      step("after_reset", 0, 1, 1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
